// File: rtl/fpmul_pad_pkg.sv
// Shared pad-link bit positions, FSM state type and beat constants for the fpmul host.
package fpmul_pad_pkg;

    localparam int PAD_OUT_W     = 23;
    localparam int PAD_IN_W      = 12;

    localparam int DATA_LSB      = 0;
    localparam int IDX_LSB       = 16;
    localparam int STB_BIT       = 18;
    localparam int GO_BIT        = 19;

    localparam int RB_LSB        = 0;
    localparam int RIDX_LSB      = 8;
    localparam int RVLD_BIT      = 10;
    localparam int BUSY_BIT      = 11;

    localparam int NUM_OP_BEATS  = 4;
    localparam int NUM_RES_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_GO,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Assemble one io_in word; [22:20] are always driven low.
    function automatic logic [PAD_OUT_W-1:0] pad_word(input logic go, input logic stb,
                                                       input logic [1:0] idx,
                                                       input logic [15:0] data);
        logic [PAD_OUT_W-1:0] w;
        w                    = '0;
        w[DATA_LSB +: 16]    = data;
        w[IDX_LSB +: 2]      = idx;
        w[STB_BIT]           = stb;
        w[GO_BIT]            = go;
        return w;
    endfunction

endpackage

// File: rtl/fpmul_pad_insync.sv
// Input capture for the chip's io_out bus: one register, or a 2-flop synchronizer
// when FPMUL_HOST_SYNC_EN is defined.
module fpmul_pad_insync #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

`ifdef FPMUL_HOST_SYNC_EN
    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end
`endif

endmodule

// File: rtl/fpmul_pad_host.sv
// Host side of the fpmul pad link: serializes an operand pair onto io_in, strobes GO,
// gathers the four result bytes from io_out. Optional macro: FPMUL_HOST_SYNC_EN.
module fpmul_pad_host #(
    parameter int BEAT_HOLD   = 2,
    parameter int GAP_CYC     = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
`ifdef FPMUL_HOST_SYNC_EN
    output logic        busy_seen,
`endif
    output logic [22:0] pad_out,
    input  logic [11:0] pad_in
);
    import fpmul_pad_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]    HOLD_LAST = 4'(BEAT_HOLD - 1);
    localparam logic [3:0]    GAP_LAST  = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [1:0]    LAST_BEAT = 2'(NUM_OP_BEATS - 1);

    state_t          state, state_nxt;
    logic [3:0]      hold_cnt, hold_nxt;
    logic [1:0]      beat, beat_nxt;
    logic [63:0]     op_sr, op_sr_nxt;
    logic [TW-1:0]   tmo_cnt, tmo_nxt;
    logic [3:0]      mask, mask_nxt;
    logic [31:0]     res_q, res_nxt;
    logic            tmo_flag, tmo_flag_nxt;
    logic            rdy_q;
    logic            accept;
    logic [11:0]     pad_s;
    logic            in_vld;
    logic [1:0]      in_idx;
    logic [7:0]      in_byte;

    fpmul_pad_insync #(.W(PAD_IN_W)) u_insync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (pad_in),
        .q   (pad_s)
    );

    assign in_vld  = pad_s[RVLD_BIT];
    assign in_idx  = pad_s[RIDX_LSB +: 2];
    assign in_byte = pad_s[RB_LSB +: 8];
    assign accept  = (state == ST_IDLE) && rdy_q && req_valid;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            beat     <= '0;
            op_sr    <= '0;
            tmo_cnt  <= '0;
            mask     <= '0;
            res_q    <= '0;
            tmo_flag <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            beat     <= beat_nxt;
            op_sr    <= op_sr_nxt;
            tmo_cnt  <= tmo_nxt;
            mask     <= mask_nxt;
            res_q    <= res_nxt;
            tmo_flag <= tmo_flag_nxt;
            rdy_q    <= (state_nxt == ST_IDLE);
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_nxt     = hold_cnt;
        beat_nxt     = beat;
        op_sr_nxt    = op_sr;
        tmo_nxt      = tmo_cnt;
        mask_nxt     = mask;
        res_nxt      = res_q;
        tmo_flag_nxt = tmo_flag;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    op_sr_nxt = {req_b, req_a};
                    beat_nxt  = '0;
                    hold_nxt  = '0;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_nxt = '0;
                    if (beat == LAST_BEAT) begin
                        state_nxt = ST_GO;
                    end else if (GAP_CYC == 0) begin
                        beat_nxt  = beat + 2'd1;
                        op_sr_nxt = op_sr >> 16;
                    end else begin
                        state_nxt = ST_GAP;
                    end
                end else begin
                    hold_nxt = hold_cnt + 4'd1;
                end
            end
            ST_GAP: begin
                // The halfword stays on the bus through the gap; shift only when moving on.
                if (hold_cnt == GAP_LAST) begin
                    hold_nxt  = '0;
                    beat_nxt  = beat + 2'd1;
                    op_sr_nxt = op_sr >> 16;
                    state_nxt = ST_SEND;
                end else begin
                    hold_nxt = hold_cnt + 4'd1;
                end
            end
            ST_GO: begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_nxt  = '0;
                    mask_nxt  = '0;
                    tmo_nxt   = '0;
                    res_nxt   = '0;
                    state_nxt = ST_WAIT;
                end else begin
                    hold_nxt = hold_cnt + 4'd1;
                end
            end
            ST_WAIT: begin
                tmo_nxt = tmo_cnt + 1'b1;
                if (in_vld) begin
                    mask_nxt[in_idx]       = 1'b1;
                    res_nxt[in_idx*8 +: 8] = in_byte;
                end
                // A byte completing the mask wins over an expiring timeout.
                if (mask_nxt == 4'hF) begin
                    tmo_flag_nxt = 1'b0;
                    state_nxt    = ST_RESP;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_flag_nxt = 1'b1;
                    state_nxt    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pad_out = '0;
        case (state)
            ST_SEND: pad_out = pad_word(1'b0, 1'b1, beat, op_sr[15:0]);
            ST_GAP:  pad_out = pad_word(1'b0, 1'b0, beat, op_sr[15:0]);
            ST_GO:   pad_out = pad_word(1'b1, 1'b0, 2'd0, 16'd0);
            default: pad_out = '0;
        endcase
    end

    assign req_ready   = rdy_q;
    assign rsp_valid   = (state == ST_RESP);
    assign rsp_result  = res_q;
    assign rsp_timeout = tmo_flag;

`ifdef FPMUL_HOST_SYNC_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                                   busy_seen <= 1'b0;
        else if (accept)                                busy_seen <= 1'b0;
        else if (state == ST_WAIT && pad_s[BUSY_BIT])   busy_seen <= 1'b1;
    end
`endif

endmodule
